// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response port: the fetch unit drives the request,
// and the memory answers with ready and data in the same cycle.
interface imem_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_data_i;

   modport master (output imem_req_o, output imem_addr_o,
                   input  imem_ready_i, input imem_data_i);
   modport slave  (input  imem_req_o, input imem_addr_o,
                   output imem_ready_i, output imem_data_i);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency instruction memory,
// and presents an instruction or an all-zero bubble to the IF/ID register each cycle.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_INC   = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   imem_if.master      imem,
   input  logic        Stall_i,
   input  logic        Branch_i,
   input  logic [31:0] BranchAddr_i,
   output logic [31:0] PC_o,
   output logic [31:0] Inst_o,
   output logic        Valid_o
);

   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_req_addr;
   logic [31:0] r_inst_buf;

   logic [31:0] w_target;
   logic [31:0] w_pc_next;

   assign w_target  = BranchAddr_i & ~32'h3;
   assign w_pc_next = r_pc + 32'(PC_INC);

   always_comb begin
      imem.imem_req_o  = 1'b0;
      imem.imem_addr_o = r_req_addr;
      Valid_o          = 1'b0;
      Inst_o           = '0;
      PC_o             = '0;
      if (!rst_i) begin
         case (r_state)
            FETCH: begin
               imem.imem_req_o = 1'b1;
               if (imem.imem_ready_i && !Branch_i) begin
                  Valid_o = 1'b1;
                  Inst_o  = imem.imem_data_i;
                  PC_o    = r_req_addr;
               end
            end
            HOLD: begin
               if (!Branch_i) begin
                  Valid_o = 1'b1;
                  Inst_o  = r_inst_buf;
                  PC_o    = r_pc;
               end
            end
            DRAIN: begin
               imem.imem_req_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= FETCH;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_inst_buf <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               if (Branch_i) begin
                  r_pc <= w_target;
                  // An unanswered request must keep its address, so drain it first
                  if (imem.imem_ready_i) r_req_addr <= w_target;
                  else                   r_state    <= DRAIN;
               end else if (imem.imem_ready_i) begin
                  if (Stall_i) begin
                     r_inst_buf <= imem.imem_data_i;
                     r_state    <= HOLD;
                  end else begin
                     r_pc       <= w_pc_next;
                     r_req_addr <= w_pc_next;
                  end
               end
            end
            HOLD: begin
               if (Branch_i) begin
                  r_pc       <= w_target;
                  r_req_addr <= w_target;
                  r_state    <= FETCH;
               end else if (!Stall_i) begin
                  r_pc       <= w_pc_next;
                  r_req_addr <= w_pc_next;
                  r_state    <= FETCH;
               end
            end
            DRAIN: begin
               if (Branch_i) begin
                  r_pc <= w_target;
                  if (imem.imem_ready_i) begin
                     r_req_addr <= w_target;
                     r_state    <= FETCH;
                  end
               end else if (imem.imem_ready_i) begin
                  r_req_addr <= r_pc;
                  r_state    <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns addr+0x100 when ready.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch;
   logic [31:0] baddr;
   logic        ready;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        valid_o;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   imem_if u_if ();

   assign u_if.imem_ready_i = ready;
   assign u_if.imem_data_i  = ready ? (u_if.imem_addr_o + 32'h100) : 32'hDEAD_BEEF;

   if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .imem         (u_if.master),
      .Stall_i      (stall),
      .Branch_i     (branch),
      .BranchAddr_i (baddr),
      .PC_o         (pc_o),
      .Inst_o       (inst_o),
      .Valid_o      (valid_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
      chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, v});
      chk({tag, ".pc"},    pc_o,   p);
      chk({tag, ".inst"},  inst_o, i);
   endtask

   task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
      chk({tag, ".req"}, {31'b0, u_if.imem_req_o}, {31'b0, r});
      if (r) chk({tag, ".addr"}, u_if.imem_addr_o, a);
   endtask

   // Advance to the next falling edge, where inputs are driven
   task automatic nxt();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch = 1'b0; baddr = '0; ready = 1'b1;
      @(negedge clk); #1;
      chk_out("reset", 1'b0, 32'h0, 32'h0);
      chk_req("reset", 1'b0, 32'h0);

      // 1-cycle memory, back-to-back fetch
      rst = 1'b0; #1;
      for (int k = 0; k < 4; k++) begin
         chk_req("seq", 1'b1, 32'(4*k));
         chk_out("seq", 1'b1, 32'(4*k), 32'h100 + 32'(4*k));
         nxt(); #1;
      end

      // 3-cycle memory from reset
      rst = 1'b1; ready = 1'b0; #1;
      nxt(); rst = 1'b0; #1;
      chk_req("slow0", 1'b1, 32'h0);
      chk_out("slow0", 1'b0, 32'h0, 32'h0);
      nxt(); #1;
      chk_req("slow1", 1'b1, 32'h0);
      chk_out("slow1", 1'b0, 32'h0, 32'h0);
      nxt(); ready = 1'b1; #1;
      chk_req("slow2", 1'b1, 32'h0);
      chk_out("slow2", 1'b1, 32'h0, 32'h100);
      nxt(); #1;
      chk_out("pc4", 1'b1, 32'h4, 32'h104);

      // Stall at PC 8 for three cycles
      nxt(); stall = 1'b1; #1;
      chk_out("stallA", 1'b1, 32'h8, 32'h108);
      nxt(); #1;
      chk_req("holdB", 1'b0, 32'h0);
      chk_out("holdB", 1'b1, 32'h8, 32'h108);
      nxt(); #1;
      chk_req("holdC", 1'b0, 32'h0);
      chk_out("holdC", 1'b1, 32'h8, 32'h108);
      nxt(); stall = 1'b0; #1;
      chk_req("holdD", 1'b0, 32'h0);
      chk_out("holdD", 1'b1, 32'h8, 32'h108);
      nxt(); #1;
      chk_req("after_hold", 1'b1, 32'hC);
      chk_out("after_hold", 1'b1, 32'hC, 32'h10C);

      // Redirect while a 4-cycle request to 16 is outstanding
      nxt(); ready = 1'b0; branch = 1'b1; baddr = 32'h43; #1;
      chk_req("drain0", 1'b1, 32'h10);
      chk_out("drain0", 1'b0, 32'h0, 32'h0);
      nxt(); branch = 1'b0; baddr = '0; #1;
      chk_req("drain1", 1'b1, 32'h10);
      chk_out("drain1", 1'b0, 32'h0, 32'h0);
      nxt(); #1;
      chk_req("drain2", 1'b1, 32'h10);
      nxt(); ready = 1'b1; #1;
      chk_req("drain3", 1'b1, 32'h10);
      chk_out("drain3", 1'b0, 32'h0, 32'h0);
      nxt(); #1;
      chk_req("target", 1'b1, 32'h40);
      chk_out("target", 1'b1, 32'h40, 32'h140);

      // Branch and stall together in a ready cycle
      nxt(); branch = 1'b1; stall = 1'b1; baddr = 32'h80; #1;
      chk_out("br_stall", 1'b0, 32'h0, 32'h0);
      nxt(); branch = 1'b0; stall = 1'b0; #1;
      chk_req("br_tgt", 1'b1, 32'h80);
      chk_out("br_tgt", 1'b1, 32'h80, 32'h180);

      // Wrap-around at the top of the address space
      nxt(); branch = 1'b1; baddr = 32'hFFFF_FFFC; #1;
      chk_out("wrap_br", 1'b0, 32'h0, 32'h0);
      nxt(); branch = 1'b0; #1;
      chk_out("wrap0", 1'b1, 32'hFFFF_FFFC, 32'h0000_00FC);
      nxt(); #1;
      chk_out("wrap1", 1'b1, 32'h0, 32'h100);

      // Reset in the middle of a pending request
      nxt(); ready = 1'b0; #1;
      chk_req("pend", 1'b1, 32'h4);
      rst = 1'b1; #1;
      chk_req("rst_mid", 1'b0, 32'h0);
      chk_out("rst_mid", 1'b0, 32'h0, 32'h0);
      nxt(); rst = 1'b0; #1;
      chk_req("rst_rel", 1'b1, 32'h0);
      nxt(); ready = 1'b1; #1;
      chk_out("rst_rel", 1'b1, 32'h0, 32'h100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
